alu_request_arbiter: RTL and testbench

//  Shares one combinational ALU between NUM_REQ requesters.

---
 rtl/alu_request_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_alu_request_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_request_arbiter.sv
// -----------------------------------------------------------------------------
// alu_request_arbiter
//   Shares one combinational ALU between NUM_REQ requesters. A round-robin
//   arbiter picks one request, registers its operands onto the ALU ports,
//   captures the ALU result one cycle later and returns it over a
//   valid/ready response channel. Only one operation is in flight at a time:
//   IDLE (grant) -> ISSUE (ALU evaluates) -> RESP (hand back) -> IDLE.
//
//   Optional build macro ALU_ARB_STATS_EN adds output_grant_count, a set of
//   per-requester 16-bit saturating accept counters.
// -----------------------------------------------------------------------------
module alu_request_arbiter #(
    parameter int WIDTH   = 64,
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                     input_clk,
    input  logic                     input_rst_n,
    input  logic [NUM_REQ-1:0]       input_req_valid,
    input  logic [4*NUM_REQ-1:0]     input_req_opcode,
    input  logic [WIDTH*NUM_REQ-1:0] input_req_a,
    input  logic [WIDTH*NUM_REQ-1:0] input_req_b,
    output logic [NUM_REQ-1:0]       output_req_ready,
    output logic [WIDTH-1:0]         output_alu_data_1,
    output logic [WIDTH-1:0]         output_alu_data_2,
    output logic [3:0]               output_alu_opcode,
    input  logic [WIDTH-1:0]         input_alu_data,
    input  logic [WIDTH-1:0]         input_alu_zero,
    output logic                     output_resp_valid,
    output logic [ID_W-1:0]          output_resp_id,
    output logic [WIDTH-1:0]         output_resp_data,
    output logic                     output_resp_zero,
    input  logic                     input_resp_ready
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [16*NUM_REQ-1:0]    output_grant_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    cand_idx;
    logic               accept;

    logic [3:0]         sel_opcode;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    int                 next_ptr;

    logic [WIDTH-1:0]   alu_data_1_q;
    logic [WIDTH-1:0]   alu_data_2_q;
    logic [3:0]         alu_opcode_q;
    logic [ID_W-1:0]    resp_id_q;
    logic [WIDTH-1:0]   resp_data_q;
    logic               resp_zero_q;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    // NOTE: every variable gets a default at the top of a combinational block so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_found && input_req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        sel_opcode = '0;
        sel_a      = '0;
        sel_b      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant_idx) begin
                sel_opcode = input_req_opcode[4*i +: 4];
                sel_a      = input_req_a[WIDTH*i +: WIDTH];
                sel_b      = input_req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    // Accept only in IDLE; gating with rst_n keeps req_ready low while reset is
    // asserted even though the state register already reads IDLE.
    assign accept           = (state_q == IDLE) && grant_found && input_rst_n;
    assign output_req_ready = accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx)
                                     : '0;

    // Next-state logic and pointer advance (one past the granted requester).
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        next_ptr = int'(grant_idx) + 1;
        if (next_ptr == NUM_REQ) begin
            next_ptr = 0;
        end
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = ISSUE;
                    rr_ptr_d = ID_W'(next_ptr);
                end
            end
            ISSUE: state_d = RESP;
            RESP: begin
                if (input_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and round-robin pointer registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge input_clk or negedge input_rst_n) begin
        if (!input_rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // ALU port and response registers: load operands on accept, capture the
    // result at the end of ISSUE, otherwise hold.
    // NOTE: these drive module outputs, so they are reset to give a defined
    // all-zero output state; they are not cleared again outside reset.
    always_ff @(posedge input_clk or negedge input_rst_n) begin
        if (!input_rst_n) begin
            alu_data_1_q <= '0;
            alu_data_2_q <= '0;
            alu_opcode_q <= '0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            resp_zero_q  <= 1'b0;
        end else begin
            if (accept) begin
                alu_data_1_q <= sel_a;
                alu_data_2_q <= sel_b;
                alu_opcode_q <= sel_opcode;
                resp_id_q    <= grant_idx;
            end
            if (state_q == ISSUE) begin
                resp_data_q <= input_alu_data;
                resp_zero_q <= |input_alu_zero;
            end
        end
    end

    assign output_alu_data_1 = alu_data_1_q;
    assign output_alu_data_2 = alu_data_2_q;
    assign output_alu_opcode = alu_opcode_q;
    assign output_resp_valid = (state_q == RESP);
    assign output_resp_id    = resp_id_q;
    assign output_resp_data  = resp_data_q;
    assign output_resp_zero  = resp_zero_q;

`ifdef ALU_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] grant_cnt_q;

    // Per-requester accept counters, saturating at 16'hFFFF.
    always_ff @(posedge input_clk or negedge input_rst_n) begin
        if (!input_rst_n) begin
            grant_cnt_q <= '0;
        end else if (accept && (grant_cnt_q[grant_idx] != 16'hFFFF)) begin
            grant_cnt_q[grant_idx] <= grant_cnt_q[grant_idx] + 16'd1;
        end
    end

    assign output_grant_count = grant_cnt_q;
`endif

endmodule

// File: tb/tb_alu_request_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_request_arbiter
//   Directed bench for alu_request_arbiter with a small behavioural ALU
//   (opcode 2 = add, opcode F = 0, otherwise subtract). Inputs are driven and
//   outputs sampled 1 ns after the falling edge. Build with ALU_ARB_STATS_EN
//   defined to also exercise the grant counters.
// -----------------------------------------------------------------------------
module tb_alu_request_arbiter;

    localparam int WIDTH   = 64;
    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [4*NUM_REQ-1:0]     req_opcode = '0;
    logic [WIDTH*NUM_REQ-1:0] req_a = '0;
    logic [WIDTH*NUM_REQ-1:0] req_b = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]         alu_data_1;
    logic [WIDTH-1:0]         alu_data_2;
    logic [3:0]               alu_opcode;
    logic [WIDTH-1:0]         alu_data;
    logic [WIDTH-1:0]         alu_zero;
    logic                     resp_valid;
    logic [ID_W-1:0]          resp_id;
    logic [WIDTH-1:0]         resp_data;
    logic                     resp_zero;
    logic                     resp_ready = 1'b0;
`ifdef ALU_ARB_STATS_EN
    logic [16*NUM_REQ-1:0]    grant_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_request_arbiter #(
        .WIDTH   (WIDTH),
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .input_clk         (clk),
        .input_rst_n       (rst_n),
        .input_req_valid   (req_valid),
        .input_req_opcode  (req_opcode),
        .input_req_a       (req_a),
        .input_req_b       (req_b),
        .output_req_ready  (req_ready),
        .output_alu_data_1 (alu_data_1),
        .output_alu_data_2 (alu_data_2),
        .output_alu_opcode (alu_opcode),
        .input_alu_data    (alu_data),
        .input_alu_zero    (alu_zero),
        .output_resp_valid (resp_valid),
        .output_resp_id    (resp_id),
        .output_resp_data  (resp_data),
        .output_resp_zero  (resp_zero),
        .input_resp_ready  (resp_ready)
`ifdef ALU_ARB_STATS_EN
        ,
        .output_grant_count(grant_count)
`endif
    );

    // Behavioural combinational ALU.
    always_comb begin
        case (alu_opcode)
            4'b0010: alu_data = alu_data_1 + alu_data_2;
            4'b1111: alu_data = '0;
            default: alu_data = alu_data_1 - alu_data_2;
        endcase
        alu_zero = {{(WIDTH-1){1'b0}}, (alu_data == '0)};
    end

    // Advance to 1 ns after the next falling edge.
    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [3:0] op,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_opcode[4*idx +: 4]     = op;
        req_a[WIDTH*idx +: WIDTH]  = a;
        req_b[WIDTH*idx +: WIDTH]  = b;
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        req_valid  = NUM_REQ'($urandom);
        req_opcode = (4*NUM_REQ)'($urandom);
        req_a      = {$urandom, $urandom, $urandom, $urandom};
        req_b      = {$urandom, $urandom, $urandom, $urandom};
        resp_ready = 1'($urandom);
        repeat (3) step();
        checks++;
        if ({req_ready, resp_valid, resp_id, resp_zero} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got ready=%b valid=%b id=%h zero=%b, expected all 0",
                     req_ready, resp_valid, resp_id, resp_zero);
        end
        checks++;
        if ({alu_data_1, alu_data_2, alu_opcode} !== '0) begin
            errors++;
            $display("FAIL reset_alu_ports: got d1=%h d2=%h op=%h, expected 0",
                     alu_data_1, alu_data_2, alu_opcode);
        end
        checks++;
        if (resp_data !== '0) begin
            errors++;
            $display("FAIL reset_resp_data: got %h, expected 0", resp_data);
        end
`ifdef ALU_ARB_STATS_EN
        checks++;
        if (grant_count !== '0) begin
            errors++;
            $display("FAIL reset_grant_count: got %h, expected 0", grant_count);
        end
`endif
        req_valid  = 2'b01;
        resp_ready = 1'b1;
        rst_n      = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, expected 01", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_single_op;
        step();
        resp_ready = 1'b1;
        set_req(0, 4'b0010, 64'd5, 64'd7);
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_grant: got %b, expected 01", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if ({req_ready, resp_valid} !== 3'b000) begin
            errors++;
            $display("FAIL single_issue_ctrl: got ready=%b valid=%b, expected 00/0",
                     req_ready, resp_valid);
        end
        checks++;
        if ({alu_opcode, alu_data_1, alu_data_2} !== {4'b0010, 64'd5, 64'd7}) begin
            errors++;
            $display("FAIL single_alu_ports: got op=%h d1=%0d d2=%0d, expected 2/5/7",
                     alu_opcode, alu_data_1, alu_data_2);
        end
        step();
        checks++;
        if ({resp_valid, resp_id, resp_zero, resp_data} !== {1'b1, 1'b0, 1'b0, 64'd12}) begin
            errors++;
            $display("FAIL single_resp: got valid=%b id=%0d zero=%b data=%0d, expected 1/0/0/12",
                     resp_valid, resp_id, resp_zero, resp_data);
        end
        step();
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_resp_drop: got valid=%b, expected 0", resp_valid);
        end
    endtask

    task automatic test_round_robin;
        logic [ID_W-1:0]  exp_id;
        logic [WIDTH-1:0] exp_data;
        int               waited;
        exp_id = 1'b1;  // the single op left the pointer at 1
        set_req(0, 4'b0010, 64'd100, 64'd1);
        set_req(1, 4'b0010, 64'd20, 64'd22);
        req_valid  = 2'b11;
        resp_ready = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            waited = 0;
            while (req_ready === '0 && waited < 6) begin
                step();
                waited++;
            end
            checks++;
            if (waited != 0) begin
                errors++;
                $display("FAIL rr_grant_latency[%0d]: waited %0d cycles, expected 0", g, waited);
            end
            checks++;
            if (req_ready !== (2'b01 << exp_id)) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got %b, expected %b", g, req_ready, 2'b01 << exp_id);
            end
            exp_data = exp_id ? 64'd42 : 64'd101;
            step();
            step();
            checks++;
            if ({resp_valid, resp_id, resp_data} !== {1'b1, exp_id, exp_data}) begin
                errors++;
                $display("FAIL rr_resp[%0d]: got valid=%b id=%0d data=%0d, expected 1/%0d/%0d",
                         g, resp_valid, resp_id, resp_data, exp_id, exp_data);
            end
            step();
            exp_id = ~exp_id;
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure;
        resp_ready = 1'b0;
        set_req(0, 4'b0010, 64'd3, 64'd4);
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL bp_wrap_grant: got %b, expected 01", req_ready);
        end
        step();
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL bp_issue_ready: got %b, expected 00", req_ready);
        end
        step();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({resp_valid, resp_id, resp_zero, resp_data, req_ready} !==
                {1'b1, 1'b0, 1'b0, 64'd7, 2'b00}) begin
                errors++;
                $display("FAIL bp_stall[%0d]: got valid=%b id=%0d zero=%b data=%0d ready=%b, expected 1/0/0/7/00",
                         c, resp_valid, resp_id, resp_zero, resp_data, req_ready);
            end
            step();
        end
        resp_ready = 1'b1;
        step();
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL bp_next_grant: got %b, expected 10", req_ready);
        end
        req_valid = '0;  // withdraw before the edge: nothing may be accepted
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL bp_drop_valid: got %b, expected 00", req_ready);
        end
        step();
        checks++;
        if ({resp_valid, alu_data_1, alu_data_2} !== {1'b0, 64'd3, 64'd4}) begin
            errors++;
            $display("FAIL bp_idle_hold: got valid=%b d1=%0d d2=%0d, expected 0/3/4",
                     resp_valid, alu_data_1, alu_data_2);
        end
    endtask

    task automatic test_zero_and_abort;
        set_req(1, 4'b1111, 64'd9, 64'd9);
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL zero_grant: got %b, expected 10", req_ready);
        end
        step();
        req_valid = '0;
        step();
        checks++;
        if ({resp_valid, resp_id, resp_zero, resp_data} !== {1'b1, 1'b1, 1'b1, 64'd0}) begin
            errors++;
            $display("FAIL zero_resp: got valid=%b id=%0d zero=%b data=%0d, expected 1/1/1/0",
                     resp_valid, resp_id, resp_zero, resp_data);
        end
        step();
        // Pointer is now 0; accept req0 so it advances to 1, then abort in ISSUE.
        set_req(0, 4'b0010, 64'd1, 64'd2);
        req_valid = 2'b01;
        step();
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        checks++;
        if ({resp_valid, req_ready, alu_opcode, alu_data_1} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got valid=%b ready=%b op=%h d1=%h, expected 0",
                     resp_valid, req_ready, alu_opcode, alu_data_1);
        end
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_resp[%0d]: got valid=%b, expected 0", c, resp_valid);
            end
        end
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL abort_rr_ptr: got %b, expected 01", req_ready);
        end
        req_valid = '0;
    endtask

`ifdef ALU_ARB_STATS_EN
    task automatic run_req1_grants(input int n);
        set_req(1, 4'b0010, 64'd1, 64'd1);
        resp_ready = 1'b1;
        for (int g = 0; g < n; g++) begin
            step();
            req_valid = 2'b10;
            #1;
            checks++;
            if (req_ready !== 2'b10) begin
                errors++;
                $display("FAIL stats_grant[%0d]: got %b, expected 10", g, req_ready);
            end
            step();
            req_valid = '0;
            step();
        end
        step();
    endtask

    task automatic test_stats;
        run_req1_grants(3);
        checks++;
        if (grant_count !== {16'd3, 16'd0}) begin
            errors++;
            $display("FAIL stats_count3: got %h, expected 00030000", grant_count);
        end
        force dut.grant_cnt_q = {16'hFFFE, 16'h0000};
        #1;
        release dut.grant_cnt_q;
        run_req1_grants(3);
        checks++;
        if (grant_count !== {16'hFFFF, 16'd0}) begin
            errors++;
            $display("FAIL stats_saturate: got %h, expected ffff0000", grant_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_backpressure();
        test_zero_and_abort();
`ifdef ALU_ARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog expired");
    end

endmodule
